// File: rtl/alu_result_display.sv
// alu_result_display: output stage of the ALU mini-project.
// Holds the adder result {ovf, sign, mag[1:0]}, keeps a saturating overflow
// count and scans a 2-digit active-low 7-segment display, blinking it while
// the held result is an overflow.
module alu_result_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [3:0] res_in,
    input  logic       clr,
    output logic [3:0] res_q,
    output logic [3:0] ovf_count,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Glyphs in {g,f,e,d,c,b,a} order, active-low.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_MAG,
        ST_BLANK1,
        ST_SGN,
        ST_BLANK2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [3:0]    held_q, held_d;
    logic [3:0]    ovf_cnt_q, ovf_cnt_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          scan_wrap;
    logic          capture_ovf;
    logic [6:0]    mag_glyph;

    assign scan_wrap   = (state_q == ST_BLANK2);
    assign capture_ovf = res_valid && !clr && res_in[3];

    // State, counters, held result and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MAG;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            held_q      <= '0;
            ovf_cnt_q   <= '0;
            an_q        <= 2'b11;
            seg_q       <= GLYPH_BLANK;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            held_q      <= held_d;
            ovf_cnt_q   <= ovf_cnt_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    // Scan FSM: each digit dwells REFRESH_DIV cycles, separated by 1-cycle blanks.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_MAG: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    state_d = ST_BLANK1;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_BLANK1: state_d = ST_SGN;
            ST_SGN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    state_d = ST_BLANK2;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_BLANK2: state_d = ST_MAG;
            default:   state_d = ST_MAG;
        endcase
    end

    // Blink phase: toggles every BLINK_DIV scans; a fresh overflow restarts it ON.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (capture_ovf) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (scan_wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Result capture and saturating overflow count; clr wins over res_valid.
    always_comb begin
        held_d    = held_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clr) begin
            held_d    = '0;
            ovf_cnt_d = '0;
        end else if (res_valid) begin
            held_d = res_in;
            if (res_in[3] && (ovf_cnt_q != 4'hF)) begin
                ovf_cnt_d = ovf_cnt_q + 4'd1;
            end
        end
    end

    // Magnitude to glyph lookup.
    always_comb begin
        mag_glyph = GLYPH_0;
        case (held_q[1:0])
            2'd0: mag_glyph = GLYPH_0;
            2'd1: mag_glyph = GLYPH_1;
            2'd2: mag_glyph = GLYPH_2;
            2'd3: mag_glyph = GLYPH_3;
            default: mag_glyph = GLYPH_0;
        endcase
    end

    // Digit enables and segments for the state being scanned right now.
    always_comb begin
        an_d  = 2'b11;
        seg_d = GLYPH_BLANK;
        case (state_q)
            ST_MAG: begin
                an_d  = 2'b10;
                seg_d = held_q[3] ? GLYPH_E : mag_glyph;
            end
            ST_SGN: begin
                an_d = 2'b01;
                // Negative zero shows no minus sign.
                if (!held_q[3] && held_q[2] && (held_q[1:0] != 2'd0)) begin
                    seg_d = GLYPH_DASH;
                end
            end
            default: begin
                an_d  = 2'b11;
                seg_d = GLYPH_BLANK;
            end
        endcase
        if (held_q[3] && !blink_on_q) begin
            an_d  = 2'b11;
            seg_d = GLYPH_BLANK;
        end
    end

    assign res_q     = held_q;
    assign ovf_count = ovf_cnt_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with REFRESH_DIV=4, BLINK_DIV=2.
// The reference model tracks the position inside the 10-cycle scan and the
// number of completed scans since the last blink restart.
module tb_alu_result_display;

    localparam int R = 4;
    localparam int B = 2;
    localparam int PERIOD = 2 * R + 2;

    logic       clk;
    logic       rst;
    logic       res_valid;
    logic [3:0] res_in;
    logic       clr;
    logic [3:0] res_q;
    logic [3:0] ovf_count;
    logic [1:0] an;
    logic [6:0] seg;

    int tests;
    int fails;

    alu_result_display #(
        .REFRESH_DIV(R),
        .BLINK_DIV  (B)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .res_valid(res_valid),
        .res_in   (res_in),
        .clr      (clr),
        .res_q    (res_q),
        .ovf_count(ovf_count),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] glyph [4];
    int         m_pos;
    int         m_scans;
    logic [3:0] m_res;
    logic [3:0] m_cnt;
    logic [1:0] m_an;
    logic [6:0] m_seg;
    bit         m_phase_on;

    initial begin
        glyph[0] = 7'b1000000;
        glyph[1] = 7'b1111001;
        glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000;
        m_pos = 0; m_scans = 0; m_res = '0; m_cnt = '0;
        m_an = 2'b11; m_seg = 7'b1111111;
    end

    // Model: outputs come from the pre-edge position/result, then everything advances.
    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0; m_scans = 0; m_res = '0; m_cnt = '0;
            m_an = 2'b11; m_seg = 7'b1111111;
        end else begin
            m_phase_on = ((m_scans / B) % 2) == 0;
            m_an = 2'b11; m_seg = 7'b1111111;
            if (m_pos < R) begin
                m_an  = 2'b10;
                m_seg = m_res[3] ? 7'b0000110 : glyph[m_res[1:0]];
            end else if (m_pos > R && m_pos < PERIOD - 1) begin
                m_an = 2'b01;
                if (!m_res[3] && m_res[2] && m_res[1:0] != 2'd0) m_seg = 7'b0111111;
            end
            if (m_res[3] && !m_phase_on) begin
                m_an = 2'b11; m_seg = 7'b1111111;
            end
            if (m_pos == PERIOD - 1) m_scans++;
            m_pos = (m_pos + 1) % PERIOD;
            if (clr) begin
                m_res = '0; m_cnt = '0;
            end else if (res_valid) begin
                m_res = res_in;
                if (res_in[3]) begin
                    m_scans = 0;
                    if (m_cnt < 4'd15) m_cnt++;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; res_valid = 1'b0; res_in = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({an, seg, res_q, ovf_count} !== {2'b11, 7'b1111111, 4'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_state got an=%b seg=%b res=%b cnt=%0d want an=11 seg=1111111 res=0000 cnt=0", an, seg, res_q, ovf_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL idle_scan t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
            if (i == 0) begin
                tests++;
                if ({an, seg} !== {2'b10, 7'b1000000}) begin
                    fails++;
                    $display("FAIL first_mag got an=%b seg=%b want an=10 seg=1000000", an, seg);
                end
            end
        end
    endtask

    task automatic test_negative(input logic [3:0] val, input logic [6:0] d0, input logic [6:0] d1, input string name);
        res_valid = 1'b1; res_in = val;
        @(negedge clk);
        res_valid = 1'b0;
        tests++;
        if ({res_q, ovf_count} !== {val, 4'h0}) begin
            fails++;
            $display("FAIL %s_capture got res=%b cnt=%0d want res=%b cnt=0", name, res_q, ovf_count, val);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL %s_model t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", name, $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
            if (an == 2'b10 || an == 2'b01) begin
                tests++;
                if (seg !== ((an == 2'b10) ? d0 : d1)) begin
                    fails++;
                    $display("FAIL %s_glyph an=%b got seg=%b want seg=%b", name, an, seg, (an == 2'b10) ? d0 : d1);
                end
            end
        end
    endtask

    task automatic test_overflow_blink();
        int visible;
        int dark;
        bit seen;
        res_valid = 1'b1; res_in = 4'b1001;
        @(negedge clk);
        res_valid = 1'b0;
        tests++;
        if (ovf_count !== 4'd1) begin
            fails++;
            $display("FAIL ovf_count_one got %0d want 1", ovf_count);
        end
        visible = 0; dark = 0;
        for (int i = 0; i < 8 * PERIOD; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL blink_model t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
            if (an == 2'b10) visible++;
            if (an == 2'b11) dark++;
            if (an == 2'b10 || an == 2'b01) begin
                tests++;
                if (seg !== ((an == 2'b10) ? 7'b0000110 : 7'b1111111)) begin
                    fails++;
                    $display("FAIL ovf_glyph an=%b got seg=%b", an, seg);
                end
            end
        end
        // 80 cycles = two full blink periods: digit0 lit for R cycles in 2 scans per ON half.
        tests++;
        if (visible != 4 * R) begin
            fails++;
            $display("FAIL blink_duty got %0d digit0 cycles want %0d", visible, 4 * R);
        end
        // Wait for the dark half, then capture a new overflow there.
        seen = 0;
        for (int i = 0; i < 4 * PERIOD && !seen; i++) begin
            @(negedge clk);
            if (((m_scans / B) % 2) != 0 && an == 2'b11 && m_pos == R + 2) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL blink_off_timeout got no dark phase within %0d cycles", 4 * PERIOD);
        end
        res_valid = 1'b1; res_in = 4'b1011;
        @(negedge clk);
        res_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < PERIOD + 2 && !seen; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL reblink_model t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
            if (an == 2'b10 && seg == 7'b0000110) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL reblink_visible got no lit E on digit0 within %0d cycles", PERIOD + 2);
        end
    endtask

    task automatic test_saturate_clear();
        int pos_before;
        res_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            res_in = {1'b1, 3'($urandom)};
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL saturate_model t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
        end
        res_valid = 1'b0;
        tests++;
        if (ovf_count !== 4'd15) begin
            fails++;
            $display("FAIL ovf_saturate got %0d want 15", ovf_count);
        end
        pos_before = m_pos;
        clr = 1'b1; res_valid = 1'b1; res_in = 4'b0011;
        @(negedge clk);
        clr = 1'b0; res_valid = 1'b0;
        tests++;
        if ({res_q, ovf_count} !== 8'h00) begin
            fails++;
            $display("FAIL clr_priority got res=%b cnt=%0d want res=0000 cnt=0", res_q, ovf_count);
        end
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL clr_scan t=%0t from pos %0d got an=%b seg=%b want an=%b seg=%b", $time, pos_before, an, seg, m_an, m_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40 * PERIOD; i++) begin
            res_valid = ($urandom_range(0, 3) == 0);
            res_in    = 4'($urandom);
            clr       = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL random_model t=%0t got an=%b seg=%b res=%b cnt=%0d want an=%b seg=%b res=%b cnt=%0d", $time, an, seg, res_q, ovf_count, m_an, m_seg, m_res, m_cnt);
            end
        end
        res_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        res_valid = 1'b1; res_in = 4'b0111;
        @(negedge clk);
        res_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
            @(negedge clk);
            if (m_pos > R + 1 && m_pos < PERIOD - 1 && an == 2'b01) seen = 1;
        end
        tests++;
        if (!seen || res_q !== 4'b0111) begin
            fails++;
            $display("FAIL mid_reset_setup got res=%b an=%b, SGN reached=%0d", res_q, an, seen);
        end
        rst = 1'b1; res_valid = 1'b1; res_in = 4'b1010; clr = 1'b0;
        @(negedge clk);
        rst = 1'b0; res_valid = 1'b0;
        tests++;
        if ({an, seg, res_q, ovf_count} !== {2'b11, 7'b1111111, 4'h0, 4'h0}) begin
            fails++;
            $display("FAIL mid_reset got an=%b seg=%b res=%b cnt=%0d want an=11 seg=1111111 res=0000 cnt=0", an, seg, res_q, ovf_count);
        end
        @(negedge clk);
        tests++;
        if ({an, seg} !== {2'b10, 7'b1000000}) begin
            fails++;
            $display("FAIL mid_reset_first_digit got an=%b seg=%b want an=10 seg=1000000", an, seg);
        end
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, res_q, ovf_count} !== {m_an, m_seg, m_res, m_cnt}) begin
                fails++;
                $display("FAIL post_reset_model t=%0t got an=%b seg=%b want an=%b seg=%b", $time, an, seg, m_an, m_seg);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; res_valid = 1'b0; res_in = '0; clr = 1'b0;
        test_reset();
        test_negative(4'b0110, 7'b0100100, 7'b0111111, "negative");
        test_negative(4'b0100, 7'b1000000, 7'b1111111, "neg_zero");
        test_overflow_blink();
        test_saturate_clear();
        test_random();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
